// File: rtl/digit_serial_adder.sv
// Digit-serial add/subtract unit: WIDTH-bit operands, DIGIT bits per cycle.
// Results are valid/ready handshaked and held until the consumer takes them.
module digit_serial_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_param
      $error("digit_serial_adder: DIGIT must divide WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t st, st_nx;

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] sum_q;
  logic             carry;
  logic             cout_q;
  logic             ovf_q;
  logic [CW-1:0]    cnt;

  logic             last;
  logic [DIGIT:0]   dsum;
  logic             msb_cin;
  logic [WIDTH-1:0] d_ext;
  logic [WIDTH-1:0] sum_shift;

  assign last = (cnt == CW'(N - 1));

  assign dsum = {1'b0, op_a[DIGIT-1:0]}
              + {1'b0, op_b[DIGIT-1:0]}
              + {{DIGIT{1'b0}}, carry};

  // carry into the top bit of the digit, recovered from its sum bit
  assign msb_cin = dsum[DIGIT-1] ^ op_a[DIGIT-1] ^ op_b[DIGIT-1];

  always_comb begin
    d_ext = '0;
    d_ext[DIGIT-1:0] = dsum[DIGIT-1:0];
  end

  // new digit enters at the top; after N cycles it lands in place
  assign sum_shift = (sum_q >> DIGIT) | (d_ext << (WIDTH - DIGIT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) st <= IDLE;
    else     st <= st_nx;
  end

  always_comb begin
    st_nx = st;
    unique case (st)
      IDLE:    if (in_valid)  st_nx = RUN;
      RUN:     if (last)      st_nx = DONE;
      DONE:    if (out_ready) st_nx = IDLE;
      default: st_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a   <= '0;
      op_b   <= '0;
      sum_q  <= '0;
      carry  <= 1'b0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      cnt    <= '0;
    end else if (st == IDLE && in_valid) begin
      op_a  <= a;
      op_b  <= sub ? ~b : b;
      carry <= sub;
      cnt   <= '0;
    end else if (st == RUN) begin
      op_a  <= op_a >> DIGIT;
      op_b  <= op_b >> DIGIT;
      carry <= dsum[DIGIT];
      sum_q <= sum_shift;
      cnt   <= cnt + CW'(1);
      if (last) begin
        cout_q <= dsum[DIGIT];
        ovf_q  <= msb_cin ^ dsum[DIGIT];
      end
    end
  end

  assign in_ready  = (st == IDLE);
  assign out_valid = (st == DONE);
  assign busy      = (st != IDLE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_digit_serial_adder.sv
// Bench for digit_serial_adder: directed table, handshake/reset corners,
// and a random sweep over DIGIT in {1,2,8,16} against a word-level model.
module tb_digit_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;
  logic        busy;

  int checks = 0;
  int failures = 0;

  digit_serial_adder #(.WIDTH(16), .DIGIT(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
  );

  logic        sw_iv  [4];
  logic        sw_ir  [4];
  logic [15:0] sw_a   [4];
  logic [15:0] sw_b   [4];
  logic        sw_sub [4];
  logic        sw_ov  [4];
  logic [15:0] sw_s   [4];
  logic        sw_c   [4];
  logic        sw_o   [4];
  logic        sw_busy[4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_sw
    localparam int DG = (gi == 0) ? 1 : (gi == 1) ? 2 : (gi == 2) ? 8 : 16;
    digit_serial_adder #(.WIDTH(16), .DIGIT(DG)) u_sw (
      .clk(clk), .rst(rst),
      .in_valid(sw_iv[gi]), .in_ready(sw_ir[gi]),
      .a(sw_a[gi]), .b(sw_b[gi]), .sub(sw_sub[gi]),
      .out_valid(sw_ov[gi]), .out_ready(1'b1),
      .sum(sw_s[gi]), .cout(sw_c[gi]), .ovf(sw_o[gi]), .busy(sw_busy[gi])
    );
  end

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic [15:0] s;
    logic        c;
    logic        o;
  } vec_t;

  vec_t vt[8];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // returns {ovf, cout, sum}
  function automatic logic [17:0] model(input logic [15:0] x,
                                        input logic [15:0] y,
                                        input logic s);
    logic [16:0] r;
    logic        o;
    r = {1'b0, x} + {1'b0, (s ? ~y : y)} + 17'(s);
    if (s) o = (x[15] != y[15]) && (r[15] != x[15]);
    else   o = (x[15] == y[15]) && (r[15] != x[15]);
    return {o, r};
  endfunction

  task automatic wait_done(output int lat);
    lat = 0;
    while (lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (out_valid) break;
    end
  endtask

  task automatic do_op(input logic [15:0] x, input logic [15:0] y,
                       input logic s, output int lat);
    @(negedge clk);
    a = x; b = y; sub = s; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_done(lat);
  endtask

  task automatic sweep_op(input int k, input logic [15:0] x,
                          input logic [15:0] y, input logic s);
    int lat;
    int exp_lat;
    logic [17:0] m;
    exp_lat = (k == 0) ? 16 : (k == 1) ? 8 : (k == 2) ? 2 : 1;
    m = model(x, y, s);
    @(negedge clk);
    sw_a[k] = x; sw_b[k] = y; sw_sub[k] = s; sw_iv[k] = 1'b1;
    @(posedge clk); #1;
    sw_iv[k] = 1'b0;
    lat = 0;
    while (lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (sw_ov[k]) break;
    end
    chk($sformatf("sweep%0d_%h_%h_%0d", k, x, y, s),
        32'({lat[7:0], sw_c[k], sw_o[k], sw_s[k]}),
        32'({8'(exp_lat), m[16], m[17], m[15:0]}));
    @(posedge clk); #1;
  endtask

  initial begin
    int lat;
    int seen;
    logic [19:0] snap;

    vt[0] = '{16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0};
    vt[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vt[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vt[3] = '{16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vt[4] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vt[5] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vt[6] = '{16'h0005, 16'h0005, 1'b1, 16'h0000, 1'b1, 1'b0};
    vt[7] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      sw_iv[k] = 1'b0; sw_a[k] = '0; sw_b[k] = '0; sw_sub[k] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state",
        32'({in_ready, out_valid, busy, cout, ovf, sum}),
        32'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000}));
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      do_op(vt[i].a, vt[i].b, vt[i].sub, lat);
      chk($sformatf("vec%0d_result", i), 32'({cout, ovf, sum}),
          32'({vt[i].c, vt[i].o, vt[i].s}));
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_done_1cyc", i),
          32'({out_valid, in_ready, busy}), 32'({1'b0, 1'b1, 1'b0}));
    end

    // backpressure: hold DONE, in_valid toggling must be ignored
    out_ready = 1'b0;
    do_op(16'h1234, 16'h4321, 1'b0, lat);
    chk("bp_latency", 32'(lat), 32'd4);
    snap = {out_valid, in_ready, busy, cout, sum};
    chk("bp_first", 32'(snap), 32'({1'b1, 1'b0, 1'b1, 1'b0, 16'h5555}));
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = ~in_valid; a = 16'(i * 7 + 1); b = 16'h00FF;
      @(posedge clk); #1;
      if ({out_valid, in_ready, busy, cout, sum} !== snap || ovf !== 1'b0)
        seen++;
    end
    chk("bp_stable_10cyc", 32'(seen), 32'd0);
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; a = 16'h0010; b = 16'h0020; sub = 1'b0;
    @(posedge clk); #1;
    chk("bp_release_idle", 32'({out_valid, in_ready, busy}),
        32'({1'b0, 1'b1, 1'b0}));
    chk("idle_retains_sum", 32'(sum), 32'h5555);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("accept_next_edge", 32'(busy), 32'd1);
    wait_done(lat);
    chk("after_bp_result", 32'({lat[7:0], cout, ovf, sum}),
        32'({8'd4, 1'b0, 1'b0, 16'h0030}));
    @(posedge clk); #1;

    // reset during second RUN cycle aborts the operation
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("rst_async", 32'({in_ready, out_valid, busy, cout, ovf, sum}),
        32'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000}));
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("rst_no_result", 32'(seen), 32'd0);
    do_op(16'h0003, 16'h0005, 1'b1, lat);
    chk("after_rst_op", 32'({lat[7:0], cout, ovf, sum}),
        32'({8'd4, 1'b0, 1'b0, 16'hFFFE}));
    @(posedge clk); #1;

    for (int k = 0; k < 4; k++) begin
      sweep_op(k, 16'hFFFF, 16'h0001, 1'b0);
      sweep_op(k, 16'h8000, 16'h0001, 1'b1);
      for (int n = 0; n < 1000; n++)
        sweep_op(k, 16'($urandom), 16'($urandom), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/digit_serial_adder.md
DIGIT_SERIAL_ADDER -- requirements
Module: digit_serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning operand/result width in bits.
REQ-002 SHALL have parameter DIGIT, default 4, meaning bits processed per clock cycle.
REQ-003 SHALL fail elaboration if WIDTH%DIGIT != 0, DIGIT < 1, or DIGIT > WIDTH.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-006 SHALL have port in_valid  input  1  operands a, b, sub are valid.
REQ-007 SHALL have port in_ready  output  1  block accepts an operation this cycle.
REQ-008 SHALL have port a  input  WIDTH  first operand.
REQ-009 SHALL have port b  input  WIDTH  second operand.
REQ-010 SHALL have port sub  input  1  0 = a+b, 1 = a-b.
REQ-011 SHALL have port out_valid  output  1  result is valid.
REQ-012 SHALL have port out_ready  input  1  consumer takes the result.
REQ-013 SHALL have port sum  output  WIDTH  result, modulo 2^WIDTH.
REQ-014 SHALL have port cout  output  1  final carry (for subtract: 1 = no borrow).
REQ-015 SHALL have port ovf  output  1  two's-complement signed overflow.
REQ-016 SHALL have port busy  output  1  high in RUN or DONE.

Function
REQ-017 SHALL implement FSM with states IDLE, RUN, DONE; N = WIDTH/DIGIT.
REQ-018 IDLE: in_ready=1, out_valid=0; on in_valid at an edge, latch a, (sub ? ~b : b), carry=sub, digit counter=0, go to RUN.
REQ-019 RUN: each cycle, add the low DIGIT bits of the latched operands plus carry; store the DIGIT-bit result; update carry; shift operands right by DIGIT; increment counter.
REQ-020 RUN SHALL last exactly N cycles, then go to DONE; an accept at edge t gives out_valid=1 after edge t+N.
REQ-021 DONE: out_valid=1, in_ready=0; sum, cout, ovf SHALL hold stable until the handshake edge (out_valid & out_ready), then go to IDLE.
REQ-022 cout SHALL equal the carry out of bit WIDTH-1.
REQ-023 ovf SHALL equal the carry into bit WIDTH-1 XOR the carry out of bit WIDTH-1.
REQ-024 in_ready SHALL be 0 in RUN and DONE; in_valid in those states SHALL be ignored, with no queuing.
REQ-025 No same-cycle accept on the DONE->IDLE edge; the next accept occurs no earlier than the following edge (throughput one operation per N+2 cycles).
REQ-026 DIGIT = WIDTH (N=1) SHALL behave identically: a single RUN cycle.
REQ-027 With out_ready held high, DONE SHALL last exactly one cycle.
REQ-028 sum, cout, ovf SHALL retain the last result in IDLE until the next accept; out_valid alone qualifies them.

Reset
REQ-029 rst=1 SHALL immediately, without a clock edge, force IDLE, counter=0, carry=0, and sum/cout/ovf/out_valid/busy=0; in_ready=1.
REQ-030 rst asserted mid-RUN or in DONE SHALL abort the operation with no result issued.
REQ-031 The first accept after release SHALL occur on the first rising edge where rst=0 and in_valid=1.

Verification (WIDTH=16, DIGIT=4)
REQ-032 a=0x0001, b=0x0001, sub=0, out_ready=1 -> sum=0x0002, cout=0, ovf=0; out_valid 4 edges after accept, high 1 cycle.
REQ-033 a=0xFFFF, b=0x0001, sub=0 -> sum=0x0000, cout=1, ovf=0; a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1.
REQ-034 a=0x0003, b=0x0005, sub=1 -> sum=0xFFFE, cout=0, ovf=0; a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, cout=1, ovf=1.
REQ-035 out_ready=0 for 10 cycles in DONE, in_valid toggling -> sum/cout/ovf stable, in_ready=0, no new accept; out_ready=1 -> IDLE next edge.
REQ-036 rst pulse during the 2nd RUN cycle -> all outputs 0 and in_ready=1 at once; no out_valid for the aborted operation; a new accept after release completes correctly.
REQ-037 Parameter sweep DIGIT in {1,2,8,16} with 1000 random operations each vs a reference model -> all sum/cout/ovf match, latency = 16/DIGIT.
